// File: rtl/dsp_mac_stream.sv
// dsp_mac_stream: streaming pre-add/multiply/accumulate engine emitting a rounded, saturated sum per frame
//   CLK/RST          clock, async active-high reset
//   s_valid/s_ready  input beat handshake; s_a, s_b, s_d operands, s_op pre-adder control, s_last frame end
//   m_valid/m_ready  result handshake; m_data sum, m_sat clipped, m_trunc closed by MAX_LEN, m_count beats
module dsp_mac_stream #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int ACC_W = 48,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0,
  parameter int MAX_LEN = 256,
  parameter int CNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [A_W-1:0]   s_a,
  input  logic signed [B_W-1:0]   s_b,
  input  logic signed [B_W-1:0]   s_d,
  input  logic [1:0]              s_op,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic                    m_sat,
  output logic                    m_trunc,
  output logic [CNT_W-1:0]        m_count
);
  localparam int P_W = A_W + B_W + 1;
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  // Half an output LSB; shifting left then right yields zero when SHIFT is 0.
  localparam logic signed [ACC_W:0] RND = ((ACC_W+1)'(1) << SHIFT) >> 1;
  logic en, take, hit, last_in, trunc_in, hi, lo;
  logic [CNT_W-1:0] cnt, cnt_n, c1, c2, c3;
  logic v1, l1, t1, v2, l2, t2, v3, l3, t3;
  logic signed [A_W-1:0] a1, a2;
  logic signed [B_W-1:0] b1, d1;
  logic [1:0] op1;
  logic signed [B_W:0] opnd, o2;
  logic signed [P_W-1:0] p3;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [ACC_W:0] rs, r;
  logic [OUT_W-1:0] od;
  always_comb begin
    en = !m_valid || m_ready;
    s_ready = en && !RST;
    take = s_valid && s_ready;
    cnt_n = cnt + CNT_W'(1);
    hit = cnt_n == CNT_W'(MAX_LEN);
    last_in = s_last || hit;
    trunc_in = hit && !s_last;
    // Operands widened by one bit first so the pre-adder cannot wrap.
    opnd = !op1[0] ? {b1[B_W-1], b1}
         : op1[1] ? {d1[B_W-1], d1} - {b1[B_W-1], b1}
         : {d1[B_W-1], d1} + {b1[B_W-1], b1};
    sum = acc + ACC_W'(p3);
    rs = $signed({sum[ACC_W-1], sum}) + RND;
    r = rs >>> SHIFT;
    hi = r > MAX_V;
    lo = r < MIN_V;
    od = hi ? MAX_V[OUT_W-1:0] : lo ? MIN_V[OUT_W-1:0] : r[OUT_W-1:0];
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      {v1, l1, t1, v2, l2, t2, v3, l3, t3} <= '0;
      {c1, c2, c3} <= '0;
      {a1, b1, d1, op1, a2, o2, p3} <= '0;
      acc <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_sat <= 1'b0;
      m_trunc <= 1'b0;
      m_count <= '0;
    end else if (en) begin
      v1 <= take;
      if (take) begin
        a1 <= s_a;
        b1 <= s_b;
        d1 <= s_d;
        op1 <= s_op;
        l1 <= last_in;
        t1 <= trunc_in;
        c1 <= cnt_n;
        cnt <= last_in ? '0 : cnt_n;
      end
      {v2, l2, t2, c2, a2, o2} <= {v1, l1, t1, c1, a1, opnd};
      {v3, l3, t3, c3} <= {v2, l2, t2, c2};
      p3 <= P_W'(a2) * P_W'(o2);
      // A new result may replace the one just consumed on the same edge.
      m_valid <= v3 && l3;
      if (v3) begin
        if (l3) begin
          acc <= '0;
          m_data <= od;
          m_sat <= hi || lo;
          m_trunc <= t3;
          m_count <= c3;
        end else begin
          acc <= sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_dsp_mac_stream.sv
// tb_dsp_mac_stream: directed self-checking bench over four parameterisations of dsp_mac_stream
module tb_dsp_mac_stream;
  typedef struct {
    longint data;
    bit sat;
    bit trunc;
    int count;
    int cyc;
  } res_t;
  logic clk, rst;
  logic sv [4];
  logic mr0, mr1, mr2, mr3;
  logic signed [17:0] sa, sb, sd;
  logic [1:0] sop;
  logic slast;
  logic sr0, sr1, sr2, sr3, mv0, mv1, mv2, mv3;
  logic ms0, ms1, ms2, ms3, mt0, mt1, mt2, mt3;
  logic signed [31:0] md0, md2, md3;
  logic signed [15:0] md1;
  logic [8:0] mc0, mc1, mc2;
  logic [2:0] mc3;
  int cyc, checks, errors, k, k2;
  res_t q0 [$], q1 [$], q2 [$], q3 [$];
  res_t r;

  dsp_mac_stream u0 (.CLK(clk), .RST(rst), .s_valid(sv[0]), .s_ready(sr0), .s_a(sa), .s_b(sb), .s_d(sd),
    .s_op(sop), .s_last(slast), .m_valid(mv0), .m_ready(mr0), .m_data(md0), .m_sat(ms0), .m_trunc(mt0), .m_count(mc0));
  dsp_mac_stream #(.OUT_W(16)) u1 (.CLK(clk), .RST(rst), .s_valid(sv[1]), .s_ready(sr1), .s_a(sa), .s_b(sb), .s_d(sd),
    .s_op(sop), .s_last(slast), .m_valid(mv1), .m_ready(mr1), .m_data(md1), .m_sat(ms1), .m_trunc(mt1), .m_count(mc1));
  dsp_mac_stream #(.SHIFT(2)) u2 (.CLK(clk), .RST(rst), .s_valid(sv[2]), .s_ready(sr2), .s_a(sa), .s_b(sb), .s_d(sd),
    .s_op(sop), .s_last(slast), .m_valid(mv2), .m_ready(mr2), .m_data(md2), .m_sat(ms2), .m_trunc(mt2), .m_count(mc2));
  dsp_mac_stream #(.MAX_LEN(4)) u3 (.CLK(clk), .RST(rst), .s_valid(sv[3]), .s_ready(sr3), .s_a(sa), .s_b(sb), .s_d(sd),
    .s_op(sop), .s_last(slast), .m_valid(mv3), .m_ready(mr3), .m_data(md3), .m_sat(ms3), .m_trunc(mt3), .m_count(mc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mv0 && mr0) q0.push_back('{longint'(md0), ms0, mt0, int'(mc0), cyc});
    if (mv1 && mr1) q1.push_back('{longint'(md1), ms1, mt1, int'(mc1), cyc});
    if (mv2 && mr2) q2.push_back('{longint'(md2), ms2, mt2, int'(mc2), cyc});
    if (mv3 && mr3) q3.push_back('{longint'(md3), ms3, mt3, int'(mc3), cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sr_of(input int u);
    return u == 0 ? sr0 : u == 1 ? sr1 : u == 2 ? sr2 : sr3;
  endfunction

  function automatic int qsize(input int u);
    return u == 0 ? q0.size() : u == 1 ? q1.size() : u == 2 ? q2.size() : q3.size();
  endfunction

  task automatic beat(input int u, input int a, input int b, input int d, input logic [1:0] op, input bit last,
                      output int acc_cyc);
    @(negedge clk);
    sa = 18'(a);
    sb = 18'(b);
    sd = 18'(d);
    sop = op;
    slast = last;
    sv[u] = 1'b1;
    for (int i = 0; i < 100 && !sr_of(u); i++) @(negedge clk);
    if (!sr_of(u)) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 sv[u] = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic get(input int u, output res_t res);
    for (int i = 0; i < 200 && qsize(u) == 0; i++) @(negedge clk);
    res = '{0, 0, 0, 0, 0};
    if (qsize(u) == 0) chk("result_timeout", 0, 1);
    else case (u)
      0: res = q0.pop_front();
      1: res = q1.pop_front();
      2: res = q2.pop_front();
      default: res = q3.pop_front();
    endcase
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) sv[i] = 1'b0;
    {mr0, mr1, mr2, mr3} = 4'hf;
    {sa, sb, sd, sop, slast} = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", mv0, 0);
    chk("rst_s_ready", sr0, 0);
    chk("rst_m_data", md0, 0);
    chk("rst_m_count", mc0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", sr0, 1);
    // plain MAC: 1*2+2*2+3*2+4*2
    for (int i = 1; i <= 4; i++) beat(0, i, 2, 0, 2'b00, i == 4, k);
    get(0, r);
    chk("t1_data", r.data, 20);
    chk("t1_count", r.count, 4);
    chk("t1_sat", r.sat, 0);
    chk("t1_trunc", r.trunc, 0);
    chk("t1_latency", r.cyc - k, 3);
    // pre-adder: (5+3)*-2 + (5-3)*4
    beat(0, -2, 3, 5, 2'b01, 0, k);
    beat(0, 4, 3, 5, 2'b11, 1, k);
    get(0, r);
    chk("t2_data", r.data, -8);
    chk("t2_count", r.count, 2);
    // saturation at OUT_W=16
    beat(1, -131072, -131072, 0, 2'b00, 0, k);
    beat(1, -131072, -131072, 0, 2'b00, 1, k);
    get(1, r);
    chk("t3_pos_data", r.data, 32767);
    chk("t3_pos_sat", r.sat, 1);
    beat(1, -131072, 131071, 0, 2'b00, 0, k);
    beat(1, -131072, 131071, 0, 2'b00, 1, k);
    get(1, r);
    chk("t3_neg_data", r.data, -32768);
    chk("t3_neg_sat", r.sat, 1);
    beat(1, 100, -3, 0, 2'b00, 1, k);
    get(1, r);
    chk("t3_small_data", r.data, -300);
    chk("t3_small_sat", r.sat, 0);
    chk("t3_small_count", r.count, 1);
    // rounding with SHIFT=2
    beat(2, 3, 1, 0, 2'b00, 1, k);
    get(2, r);
    chk("t4_pos_data", r.data, 1);
    beat(2, -3, 1, 0, 2'b00, 1, k);
    get(2, r);
    chk("t4_neg_data", r.data, -1);
    beat(2, 6, 1, 0, 2'b00, 1, k);
    get(2, r);
    chk("t4_six_data", r.data, 2);
    chk("t4_six_sat", r.sat, 0);
    // MAX_LEN=4 auto-close, then the remainder frame back-to-back
    for (int i = 1; i <= 6; i++) beat(3, 1, 1, 0, 2'b00, i == 6, k);
    get(3, r);
    chk("t5a_data", r.data, 4);
    chk("t5a_count", r.count, 4);
    chk("t5a_trunc", r.trunc, 1);
    get(3, r);
    chk("t5b_data", r.data, 2);
    chk("t5b_count", r.count, 2);
    chk("t5b_trunc", r.trunc, 0);
    // backpressure: hold the result, a pending beat must wait and not be lost
    mr0 = 1'b0;
    beat(0, 7, 1, 0, 2'b00, 1, k);
    for (int i = 0; i < 50 && !mv0; i++) @(negedge clk);
    chk("t6_pending_valid", mv0, 1);
    fork
      begin
        beat(0, 2, 1, 0, 2'b00, 0, k2);
        beat(0, 3, 1, 0, 2'b00, 1, k2);
      end
    join_none
    repeat (10) begin
      @(negedge clk);
      chk("t6_stall_ready", sr0, 0);
      chk("t6_stall_valid", mv0, 1);
      chk("t6_stall_data", md0, 7);
    end
    @(posedge clk);
    #1 mr0 = 1'b1;
    get(0, r);
    chk("t6_held_data", r.data, 7);
    chk("t6_held_count", r.count, 1);
    get(0, r);
    chk("t6_next_data", r.data, 5);
    chk("t6_next_count", r.count, 2);
    // reset mid-frame discards partial sum and beat count
    beat(0, 100, 1, 0, 2'b00, 0, k);
    beat(0, 50, 1, 0, 2'b00, 0, k);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", mv0, 0);
    chk("t6_rst_ready", sr0, 0);
    @(negedge clk);
    rst = 1'b0;
    beat(0, 3, 1, 0, 2'b00, 1, k);
    get(0, r);
    chk("t6_after_rst_data", r.data, 3);
    chk("t6_after_rst_count", r.count, 1);
    repeat (5) @(negedge clk);
    chk("t6_no_stray_result", q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
